// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage and MEM/WB register ahead of write-back.
// Runs load/store handshakes with data memory and stalls EX while an access is pending.
// Optional access watchdog: define MEM_TIMEOUT_EN to enable it (TIMEOUT cycles).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid, in_WC, in_PC,
//   in_alu_res, in_store_data,
//   in_mem_rd, in_mem_wr,
//   in_S_MXRB, in_W_RB, in_flush    instruction from EX plus kill
//   out_stall                       combinational hold request to upstream
//   out_dm_req/we/addr/wdata,
//   in_dm_ack, in_dm_rdata          data-memory handshake
//   out_WC/PC/PR/alu_res/
//   out_S_MXRB/W_RB                 MEM/WB register
//   out_dm_err                      one-cycle pulse on access timeout
module mem_access_stage #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [3:0]    in_WC,
    input  logic [DW-1:0] in_PC,
    input  logic [DW-1:0] in_alu_res,
    input  logic [DW-1:0] in_store_data,
    input  logic          in_mem_rd,
    input  logic          in_mem_wr,
    input  logic [1:0]    in_S_MXRB,
    input  logic          in_W_RB,
    input  logic          in_flush,
    output logic          out_stall,
    output logic          out_dm_req,
    output logic          out_dm_we,
    output logic [DW-1:0] out_dm_addr,
    output logic [DW-1:0] out_dm_wdata,
    input  logic          in_dm_ack,
    input  logic [DW-1:0] in_dm_rdata,
    output logic [3:0]    out_WC,
    output logic [DW-1:0] out_PC,
    output logic [DW-1:0] out_PR,
    output logic [DW-1:0] out_alu_res,
    output logic [1:0]    out_S_MXRB,
    output logic          out_W_RB,
    output logic          out_dm_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    wc_q, wc_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] pr_q, pr_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [1:0]    mx_q, mx_d;
    logic          wrb_q, wrb_d;
    logic          err_q, err_d;
    logic          stall;
    logic          tmo;
    logic          is_mem;

    assign is_mem = in_mem_rd | in_mem_wr;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter sits at zero in IDLE, so entering ACCESS starts from zero.
    assign cnt_d = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    assign tmo   = (state_q != IDLE) && !in_dm_ack
                && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        // MEM/WB updates every cycle; a fully zeroed bubble is the default.
        wc_d    = '0;
        pc_d    = '0;
        pr_d    = '0;
        alu_d   = '0;
        mx_d    = '0;
        wrb_d   = 1'b0;
        err_d   = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !in_flush) begin
                    if (is_mem) begin
                        stall   = 1'b1;
                        req_d   = 1'b1;
                        we_d    = in_mem_wr;
                        addr_d  = in_alu_res;
                        wdata_d = in_store_data;
                        state_d = ACCESS;
                    end else begin
                        wc_d  = in_WC;
                        pc_d  = in_PC;
                        alu_d = in_alu_res;
                        mx_d  = in_S_MXRB;
                        wrb_d = in_W_RB;
                    end
                end
            end
            ACCESS: begin
                if (in_dm_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!in_flush) begin
                        wc_d  = in_WC;
                        pc_d  = in_PC;
                        pr_d  = we_q ? '0 : in_dm_rdata;
                        alu_d = in_alu_res;
                        mx_d  = in_S_MXRB;
                        wrb_d = in_W_RB;
                    end
                end else if (tmo) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    // The request stays up; only its result is discarded.
                    if (in_flush) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (in_dm_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (tmo) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wc_q    <= '0;
            pc_q    <= '0;
            pr_q    <= '0;
            alu_q   <= '0;
            mx_q    <= '0;
            wrb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wc_q    <= wc_d;
            pc_q    <= pc_d;
            pr_q    <= pr_d;
            alu_q   <= alu_d;
            mx_q    <= mx_d;
            wrb_q   <= wrb_d;
            err_q   <= err_d;
        end
    end

    assign out_stall    = stall;
    assign out_dm_req   = req_q;
    assign out_dm_we    = we_q;
    assign out_dm_addr  = addr_q;
    assign out_dm_wdata = wdata_q;
    assign out_WC       = wc_q;
    assign out_PC       = pc_q;
    assign out_PR       = pr_q;
    assign out_alu_res  = alu_q;
    assign out_S_MXRB   = mx_q;
    assign out_W_RB     = wrb_q;
    assign out_dm_err   = err_q;

endmodule
